// File: rtl/core_fetch.sv
// Instruction fetch stage: owns the PC, issues one-at-a-time word requests to
// instruction memory and hands fetched words to decode through a small FIFO.
module core_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_ACK,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        INST_VALID,
  output logic [31:0] INST,
  output logic [31:0] INST_PC,
  input  logic        DEC_READY
);

  localparam int unsigned AW    = $clog2(BUF_DEPTH);
  localparam logic [AW:0] DEPTH = (AW + 1)'(BUF_DEPTH);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;

  logic [31:0]   buf_inst [BUF_DEPTH];
  logic [31:0]   buf_pc   [BUF_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;

  logic ack, push, pop;

  // In REQ nothing is outstanding, so the credit rule reduces to FIFO space.
  assign IMEM_REQ   = (state == REQ) && (count < DEPTH);
  assign IMEM_ADDR  = pc;
  assign ack        = IMEM_REQ && IMEM_ACK;
  assign push       = (state == WAIT) && IMEM_RVALID && !REDIRECT;
  assign pop        = INST_VALID && DEC_READY && !REDIRECT;
  assign INST_VALID = (count != '0);
  assign INST       = INST_VALID ? buf_inst[rd_ptr] : NOP;
  assign INST_PC    = INST_VALID ? buf_pc[rd_ptr] : 32'h0;

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    state_next = state;
    pc_next    = pc;
    case (state)
      IDLE: state_next = REQ;
      REQ: begin
        if (ack) begin
          // An accepted request is stale if a redirect lands the same cycle.
          state_next = REDIRECT ? DROP : WAIT;
          pc_next    = pc + 32'd4;
        end
      end
      WAIT: begin
        if (IMEM_RVALID)   state_next = REQ;
        else if (REDIRECT) state_next = DROP;
      end
      DROP: begin
        if (IMEM_RVALID) state_next = REQ;
      end
      default: state_next = IDLE;
    endcase
    if (REDIRECT) pc_next = {REDIRECT_PC[31:2], 2'b00};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (REDIRECT) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1;
      if (pop)  rd_ptr <= rd_ptr + 1;
      case ({push, pop})
        2'b10:   count <= count + 1;
        2'b01:   count <= count - 1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; count gates every read of it.
  always_ff @(posedge CLK) begin
    if (push) begin
      buf_inst[wr_ptr] <= IMEM_RDATA;
      // PC already advanced past the request when it was accepted.
      buf_pc[wr_ptr]   <= pc - 32'd4;
    end
  end

endmodule
